// File: rtl/vemicry_pkg.sv
// vemicry_pkg: shared opcodes, sequencer states and default widths for the VeMICry vector unit.
package vemicry_pkg;
  localparam int VLEN_MAX = 8;
  localparam int EIDX_W   = 3;
  localparam int RADD_W   = 3;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  typedef enum logic [1:0] {VOP_NOP, VOP_ALU, VOP_LD, VOP_ST} vop_e;
  typedef enum logic [1:0] {IDLE, RUN_ALU, MEM, DRAIN} state_e;
endpackage

// File: rtl/vec_addr_gen.sv
// vec_addr_gen: strided address register, element counter and last-element flag.
module vec_addr_gen #(
  parameter int EIDX_W = vemicry_pkg::EIDX_W,
  parameter int ADDR_W = vemicry_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [EIDX_W:0]   vlen_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [EIDX_W:0]   idx_o,
  output logic              last_o
);
  logic [ADDR_W-1:0] addr_q, stride_q;
  logic [EIDX_W:0]   idx_q, vlen_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      vlen_q   <= '0;
    end else if (load_i) begin
      addr_q   <= base_i;
      stride_q <= stride_i;
      idx_q    <= '0;
      vlen_q   <= vlen_i;
    end else if (step_i) begin
      addr_q <= addr_q + stride_q;
      idx_q  <= idx_q + (EIDX_W+1)'(1);
    end
  end
  assign addr_o = addr_q;
  assign idx_o  = idx_q;
  assign last_o = idx_q == vlen_q - (EIDX_W+1)'(1);
endmodule

// File: rtl/vec_seq_ctrl.sv
// vec_seq_ctrl: walks one vector instruction element by element over the VRF and data-memory port.
module vec_seq_ctrl #(
  parameter int VLEN_MAX = vemicry_pkg::VLEN_MAX,
  parameter int EIDX_W   = vemicry_pkg::EIDX_W,
  parameter int RADD_W   = vemicry_pkg::RADD_W,
  parameter int DATA_W   = vemicry_pkg::DATA_W,
  parameter int ADDR_W   = vemicry_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [1:0]        issue_op,
  input  logic [RADD_W-1:0] issue_vs,
  input  logic [RADD_W-1:0] issue_vt,
  input  logic [RADD_W-1:0] issue_vd,
  input  logic [ADDR_W-1:0] issue_base,
  input  logic [ADDR_W-1:0] issue_stride,
  input  logic [EIDX_W:0]   issue_vlen,
  output logic              pipe_stall,
  output logic [RADD_W-1:0] vrf_rs_add,
  output logic [RADD_W-1:0] vrf_rt_add,
  output logic [EIDX_W-1:0] vrf_ridx,
  input  logic [DATA_W-1:0] vrf_rt_data,
  output logic              vrf_we,
  output logic [RADD_W-1:0] vrf_wd_add,
  output logic [EIDX_W-1:0] vrf_widx,
  output logic              vrf_wsel_mem,
  output logic [DATA_W-1:0] mem_rdata_q,
  output logic              data_read,
  output logic              data_write,
  output logic [ADDR_W-1:0] data_add,
  output logic [DATA_W-1:0] data_in_mem,
  input  logic [DATA_W-1:0] memdataout,
  input  logic              mem_ready,
  output logic              done
);
  import vemicry_pkg::*;
  state_e            state_q, state_d;
  vop_e              op_q;
  logic [RADD_W-1:0] vs_q, vt_q, vd_q;
  logic [EIDX_W-1:0] widx_q;
  logic [DATA_W-1:0] rdata_q;
  logic              gap_q, gap_d, wb_q, wb_d, wsel_q, wsel_d;
  logic              accept, load, step, last, req;
  logic [EIDX_W:0]   idx, vlen_c;
  logic [ADDR_W-1:0] addr;
  assign accept = state_q == IDLE && issue_valid && issue_op != VOP_NOP && issue_vlen != '0;
  assign vlen_c = issue_vlen > (EIDX_W+1)'(VLEN_MAX) ? (EIDX_W+1)'(VLEN_MAX) : issue_vlen;
  vec_addr_gen #(.EIDX_W(EIDX_W), .ADDR_W(ADDR_W)) u_agen (
    .clock(clock), .reset(reset), .load_i(load), .step_i(step),
    .base_i(issue_base), .stride_i(issue_stride), .vlen_i(vlen_c),
    .addr_o(addr), .idx_o(idx), .last_o(last)
  );
  // gap_q forces the one idle cycle between memory requests
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    gap_d   = gap_q;
    wb_d    = 1'b0;
    wsel_d  = wsel_q;
    case (state_q)
      IDLE: if (accept) begin
        load    = 1'b1;
        gap_d   = 1'b0;
        state_d = issue_op == VOP_ALU ? RUN_ALU : MEM;
      end
      RUN_ALU: begin
        step    = 1'b1;
        wb_d    = 1'b1;
        wsel_d  = 1'b0;
        state_d = last ? DRAIN : RUN_ALU;
      end
      MEM: if (gap_q) gap_d = 1'b0;
        else if (mem_ready) begin
          step    = 1'b1;
          wb_d    = op_q == VOP_LD;
          wsel_d  = 1'b1;
          gap_d   = !last;
          state_d = last ? DRAIN : MEM;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= VOP_NOP;
      vs_q    <= '0;
      vt_q    <= '0;
      vd_q    <= '0;
      widx_q  <= '0;
      rdata_q <= '0;
      gap_q   <= 1'b0;
      wb_q    <= 1'b0;
      wsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wb_q    <= wb_d;
      wsel_q  <= wsel_d;
      if (load) begin
        op_q <= vop_e'(issue_op);
        vs_q <= issue_vs;
        vt_q <= issue_vt;
        vd_q <= issue_vd;
      end
      if (step) widx_q <= idx[EIDX_W-1:0];
      if (step && op_q == VOP_LD) rdata_q <= memdataout;
    end
  end
  assign req          = state_q == MEM && !gap_q;
  assign pipe_stall   = state_q != IDLE;
  assign done         = state_q == DRAIN;
  assign data_read    = req && op_q == VOP_LD;
  assign data_write   = req && op_q == VOP_ST;
  assign data_add     = addr;
  assign data_in_mem  = data_write ? vrf_rt_data : '0;
  assign vrf_rs_add   = vs_q;
  assign vrf_rt_add   = vt_q;
  assign vrf_ridx     = idx[EIDX_W-1:0];
  assign vrf_we       = wb_q;
  assign vrf_wd_add   = vd_q;
  assign vrf_widx     = widx_q;
  assign vrf_wsel_mem = wsel_q;
  assign mem_rdata_q  = rdata_q;
endmodule

// File: tb/tb_vec_seq_ctrl.sv
// tb_vec_seq_ctrl: directed scenario bench for the vector sequencer.
module tb_vec_seq_ctrl;
  logic        clock = 1'b0, reset;
  logic        issue_valid;
  logic [1:0]  issue_op;
  logic [2:0]  issue_vs, issue_vt, issue_vd;
  logic [31:0] issue_base, issue_stride;
  logic [3:0]  issue_vlen;
  logic        pipe_stall, vrf_we, vrf_wsel_mem, data_read, data_write, mem_ready, done;
  logic [2:0]  vrf_rs_add, vrf_rt_add, vrf_ridx, vrf_wd_add, vrf_widx;
  logic [31:0] vrf_rt_data, mem_rdata_q, data_add, data_in_mem, memdataout;
  int checks = 0, failures = 0;
  int wait_n = 0, wcnt;
  logic [31:0] q_addr[$], q_sd[$], q_wdat[$];
  logic [2:0]  q_wadd[$];
  int          q_widx[$];
  int n_req, n_stall;
  always #5 clock = ~clock;
  vec_seq_ctrl dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vs(issue_vs), .issue_vt(issue_vt), .issue_vd(issue_vd),
    .issue_base(issue_base), .issue_stride(issue_stride), .issue_vlen(issue_vlen),
    .pipe_stall(pipe_stall), .vrf_rs_add(vrf_rs_add), .vrf_rt_add(vrf_rt_add),
    .vrf_ridx(vrf_ridx), .vrf_rt_data(vrf_rt_data), .vrf_we(vrf_we),
    .vrf_wd_add(vrf_wd_add), .vrf_widx(vrf_widx), .vrf_wsel_mem(vrf_wsel_mem),
    .mem_rdata_q(mem_rdata_q), .data_read(data_read), .data_write(data_write),
    .data_add(data_add), .data_in_mem(data_in_mem), .memdataout(memdataout),
    .mem_ready(mem_ready), .done(done)
  );
  // VRF and memory stand-ins: data encodes register/index or address
  assign vrf_rt_data = {16'hDA00, 5'd0, vrf_rt_add, 5'd0, vrf_ridx};
  assign memdataout  = {16'hC0DE, data_add[15:0]};
  assign mem_ready   = (data_read || data_write) && wcnt == wait_n;
  always @(posedge clock or negedge reset)
    if (!reset) wcnt <= 0;
    else wcnt <= ((data_read || data_write) && !mem_ready) ? wcnt + 1 : 0;
  task automatic issue(input logic [1:0] op, input logic [2:0] vs, input logic [2:0] vt,
                       input logic [2:0] vd, input logic [31:0] base, input logic [31:0] stride,
                       input logic [3:0] vlen);
    issue_op = op; issue_vs = vs; issue_vt = vt; issue_vd = vd;
    issue_base = base; issue_stride = stride; issue_vlen = vlen; issue_valid = 1'b1;
    @(posedge clock); #1;
    issue_valid = 1'b0; issue_op = 2'd0;
  endtask
  task automatic run_collect(input int maxc, output int done_cyc);
    logic prev_req = 1'b0;
    done_cyc = 0; n_req = 0; n_stall = 0;
    q_addr.delete(); q_sd.delete(); q_wdat.delete(); q_wadd.delete(); q_widx.delete();
    for (int c = 1; c <= maxc && done_cyc == 0; c++) begin
      if (mem_ready) begin q_addr.push_back(data_add); q_sd.push_back(data_in_mem); end
      if ((data_read || data_write) && !prev_req) n_req++;
      prev_req = data_read || data_write;
      if (vrf_we) begin
        q_widx.push_back(int'(vrf_widx)); q_wadd.push_back(vrf_wd_add);
        q_wdat.push_back(vrf_wsel_mem ? mem_rdata_q : 32'hFFFF_FFFF);
      end
      if (pipe_stall) n_stall++;
      if (done) done_cyc = c;
      @(posedge clock); #1;
    end
  endtask
  task automatic test_reset;
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", pipe_stall); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (vrf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", vrf_we); end
    checks++; if ({data_read, data_write} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {data_read, data_write}); end
    checks++; if (data_add !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", data_add); end
    checks++; if (mem_rdata_q !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata_q); end
  endtask
  task automatic test_valu;
    issue(2'd1, 3'd1, 3'd3, 3'd2, 32'h0, 32'h0, 4'd4);
    for (int c = 1; c <= 6; c++) begin
      checks++; if (pipe_stall !== (c <= 5)) begin failures++; $display("FAIL valu_stall c=%0d got=%b exp=%b", c, pipe_stall, c <= 5); end
      checks++; if (vrf_we !== (c >= 2 && c <= 5)) begin failures++; $display("FAIL valu_we c=%0d got=%b exp=%b", c, vrf_we, c >= 2 && c <= 5); end
      checks++; if (done !== (c == 5)) begin failures++; $display("FAIL valu_done c=%0d got=%b exp=%b", c, done, c == 5); end
      if (c >= 2 && c <= 5) begin
        checks++; if (vrf_widx !== 3'(c - 2)) begin failures++; $display("FAIL valu_widx c=%0d got=%0d exp=%0d", c, vrf_widx, c - 2); end
        checks++; if ({vrf_wd_add, vrf_wsel_mem} !== {3'd2, 1'b0}) begin failures++; $display("FAIL valu_wdst c=%0d got=%0d/%b exp=2/0", c, vrf_wd_add, vrf_wsel_mem); end
      end
      if (c <= 4) begin
        checks++; if ({vrf_rs_add, vrf_ridx} !== {3'd1, 3'(c - 1)}) begin failures++; $display("FAIL valu_read c=%0d got=%0d/%0d exp=1/%0d", c, vrf_rs_add, vrf_ridx, c - 1); end
      end
      @(posedge clock); #1;
    end
  endtask
  task automatic test_vload;
    int dc;
    wait_n = 2;
    issue(2'd2, 3'd0, 3'd0, 3'd6, 32'h100, 32'd4, 4'd3);
    run_collect(40, dc);
    checks++; if (dc !== 12) begin failures++; $display("FAIL vload_done_cycle got=%0d exp=12", dc); end
    checks++; if (n_req !== 3) begin failures++; $display("FAIL vload_requests got=%0d exp=3", n_req); end
    checks++; if (q_addr.size() !== 3 || q_widx.size() !== 3) begin failures++; $display("FAIL vload_counts got=%0d/%0d exp=3/3", q_addr.size(), q_widx.size()); end
    for (int k = 0; k < 3 && k < q_addr.size(); k++) begin
      checks++; if (q_addr[k] !== 32'h100 + 32'(4 * k)) begin failures++; $display("FAIL vload_addr k=%0d got=%h exp=%h", k, q_addr[k], 32'h100 + 32'(4 * k)); end
    end
    for (int k = 0; k < 3 && k < q_widx.size(); k++) begin
      checks++; if (q_widx[k] !== k || q_wadd[k] !== 3'd6) begin failures++; $display("FAIL vload_wdst k=%0d got=%0d/%0d exp=%0d/6", k, q_widx[k], q_wadd[k], k); end
      checks++; if (q_wdat[k] !== 32'hC0DE_0100 + 32'(4 * k)) begin failures++; $display("FAIL vload_wdata k=%0d got=%h exp=%h", k, q_wdat[k], 32'hC0DE_0100 + 32'(4 * k)); end
    end
  endtask
  task automatic test_vstore;
    int dc;
    logic [31:0] ea [2];
    logic [31:0] ed [2];
    ea[0] = 32'hFFFF_FFF8; ea[1] = 32'h0; ed[0] = 32'hDA00_0500; ed[1] = 32'hDA00_0501;
    wait_n = 0;
    issue(2'd3, 3'd0, 3'd5, 3'd0, 32'hFFFF_FFF8, 32'd8, 4'd2);
    run_collect(20, dc);
    checks++; if (dc !== 4) begin failures++; $display("FAIL vstore_done_cycle got=%0d exp=4", dc); end
    checks++; if (n_req !== 2 || q_addr.size() !== 2) begin failures++; $display("FAIL vstore_requests got=%0d/%0d exp=2/2", n_req, q_addr.size()); end
    checks++; if (q_widx.size() !== 0) begin failures++; $display("FAIL vstore_no_we got=%0d exp=0", q_widx.size()); end
    for (int k = 0; k < 2 && k < q_addr.size(); k++) begin
      checks++; if (q_addr[k] !== ea[k]) begin failures++; $display("FAIL vstore_addr k=%0d got=%h exp=%h", k, q_addr[k], ea[k]); end
      checks++; if (q_sd[k] !== ed[k]) begin failures++; $display("FAIL vstore_data k=%0d got=%h exp=%h", k, q_sd[k], ed[k]); end
    end
  endtask
  task automatic test_nop_and_clamp;
    int dc;
    issue(2'd0, 3'd1, 3'd2, 3'd3, 32'h40, 32'd4, 4'd4);
    run_collect(6, dc);
    checks++; if (dc !== 0 || n_stall !== 0 || n_req !== 0) begin failures++; $display("FAIL nop_idle got=%0d/%0d/%0d exp=0/0/0", dc, n_stall, n_req); end
    issue(2'd1, 3'd1, 3'd2, 3'd3, 32'h40, 32'd4, 4'd0);
    run_collect(6, dc);
    checks++; if (dc !== 0 || n_stall !== 0 || q_widx.size() !== 0) begin failures++; $display("FAIL vlen0_idle got=%0d/%0d/%0d exp=0/0/0", dc, n_stall, q_widx.size()); end
    issue(2'd1, 3'd1, 3'd2, 3'd3, 32'h0, 32'h0, 4'd12);
    run_collect(20, dc);
    checks++; if (dc !== 9 || n_stall !== 9) begin failures++; $display("FAIL clamp_len got=%0d/%0d exp=9/9", dc, n_stall); end
    checks++; if (q_widx.size() !== 8) begin failures++; $display("FAIL clamp_writes got=%0d exp=8", q_widx.size()); end
    for (int k = 0; k < q_widx.size(); k++) begin
      checks++; if (q_widx[k] !== k) begin failures++; $display("FAIL clamp_widx k=%0d got=%0d exp=%0d", k, q_widx[k], k); end
    end
  endtask
  task automatic test_reset_abort;
    int dc;
    wait_n = 10;
    issue(2'd2, 3'd0, 3'd0, 3'd1, 32'h200, 32'd4, 4'd4);
    @(posedge clock); #1;
    checks++; if (data_read !== 1'b1 || data_add !== 32'h200) begin failures++; $display("FAIL abort_pre got=%b/%h exp=1/00000200", data_read, data_add); end
    reset = 1'b0; #1;
    checks++; if (data_read !== 1'b0 || pipe_stall !== 1'b0) begin failures++; $display("FAIL abort_async got=%b/%b exp=0/0", data_read, pipe_stall); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      checks++; if (vrf_we !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_quiet got=%b/%b exp=0/0", vrf_we, done); end
    end
    #2 reset = 1'b1; wait_n = 0;
    @(posedge clock); #1;
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", pipe_stall); end
    issue(2'd1, 3'd1, 3'd2, 3'd7, 32'h0, 32'h0, 4'd2);
    run_collect(10, dc);
    checks++; if (dc !== 3 || q_widx.size() !== 2 || n_stall !== 3) begin failures++; $display("FAIL abort_reissue got=%0d/%0d/%0d exp=3/2/3", dc, q_widx.size(), n_stall); end
  endtask
  task automatic test_back_to_back;
    int n_done = 0, n_we = 0, n_rd = 0;
    issue(2'd1, 3'd1, 3'd2, 3'd4, 32'h0, 32'h0, 4'd3);
    for (int c = 1; c <= 8; c++) begin
      issue_valid = (c <= 4) && (c % 2 == 1);
      issue_op = 2'd2; issue_vlen = 4'd5;
      if (done) n_done++;
      if (vrf_we) n_we++;
      if (data_read) n_rd++;
      @(posedge clock); #1;
    end
    issue_valid = 1'b0; issue_op = 2'd0;
    checks++; if (n_done !== 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", n_done); end
    checks++; if (n_we !== 3 || n_rd !== 0) begin failures++; $display("FAIL busy_ignored got=%0d/%0d exp=3/0", n_we, n_rd); end
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL busy_final_idle got=%b exp=0", pipe_stall); end
  endtask
  initial begin
    reset = 1'b0; issue_valid = 1'b0; issue_op = 2'd0; issue_vs = 3'd0; issue_vt = 3'd0;
    issue_vd = 3'd0; issue_base = 32'h0; issue_stride = 32'h0; issue_vlen = 4'd0;
    repeat (2) @(posedge clock);
    #1 test_reset;
    #2 reset = 1'b1;
    @(posedge clock); #1;
    test_valu;
    test_vload;
    test_vstore;
    test_nop_and_clamp;
    test_reset_abort;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_seq_ctrl.md
# vec_seq_ctrl

Vector instruction sequencer for the VeMICry core. It accepts one decoded vector instruction from the ID stage and walks its elements one at a time, driving vector-register-file read/write addresses and the shared data-memory port. It holds the scalar pipeline via `pipe_stall` until the last element is retired.

## Interface
Parameters:
- `VLEN_MAX`, 8: maximum elements per vector register
- `EIDX_W`, 3: element index width, log2(VLEN_MAX)
- `RADD_W`, 3: vector register address width
- `DATA_W`, 32: element and memory data width
- `ADDR_W`, 32: memory address width

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `issue_valid`  in  1  decoded vector instruction present
- `issue_op`  in  2  0 = NOP, 1 = VALU, 2 = VLOAD, 3 = VSTORE
- `issue_vs`, `issue_vt`, `issue_vd`  in  RADD_W each  source, source/store-data, and destination registers
- `issue_base`  in  ADDR_W  memory base address (RS value)
- `issue_stride`  in  ADDR_W  byte stride (RT value)
- `issue_vlen`  in  EIDX_W+1  element count; 0 = no-op
- `pipe_stall`  out  1  freeze the scalar pipeline
- `vrf_rs_add`, `vrf_rt_add`  out  RADD_W each  VRF read register addresses
- `vrf_ridx`  out  EIDX_W  VRF read element index
- `vrf_rt_data`  in  DATA_W  VRF read data for `vrf_rt_add`; combinational, same cycle
- `vrf_we`  out  1  VRF write enable
- `vrf_wd_add`  out  RADD_W  VRF write register address
- `vrf_widx`  out  EIDX_W  VRF write element index
- `vrf_wsel_mem`  out  1  write source: 1 = `mem_rdata_q`, 0 = ALU
- `mem_rdata_q`  out  DATA_W  registered load data
- `data_read`, `data_write`  out  1 each  memory request strobes
- `data_add`  out  ADDR_W  memory address
- `data_in_mem`  out  DATA_W  store data
- `memdataout`  in  DATA_W  load data
- `mem_ready`  in  1  memory completes the current request this cycle
- `done`  out  1  one-cycle pulse when the instruction retires

## Operation
- States: IDLE, RUN_ALU, MEM, DRAIN.
- Reset values: state IDLE; every output 0; element counters 0.
- **Accept** occurs in IDLE only, on `issue_valid` with `issue_op` ≠ 0 and `issue_vlen` ≠ 0.
  - Latch op, registers, base, stride, vlen.
  - Set address register to `issue_base` and read index to 0.
  - Go to RUN_ALU for VALU, MEM for VLOAD/VSTORE.
- NOP, or `issue_vlen` = 0, leaves the block in IDLE. No stall is raised and `done` does not pulse.
- `issue_vlen` > VLEN_MAX is clamped to VLEN_MAX.
- `pipe_stall` = (state ≠ IDLE), decoded from the state register.
- **RUN_ALU**
  - Each cycle, drive `vrf_ridx` = i and increment i.
  - One cycle later, assert `vrf_we` with `vrf_widx` = i, `vrf_wsel_mem` = 0.
  - After element vlen-1 is read, go to DRAIN.
- **MEM**
  - Drive `data_add` = address register.
  - VLOAD: assert `data_read`.
  - VSTORE: assert `data_write`, `data_in_mem` = `vrf_rt_data`, `vrf_ridx` = i.
  - Strobes, address and data stay stable until `mem_ready`.
  - On `mem_ready`:
    - Address register += stride, modulo 2^ADDR_W (wrap-around allowed).
    - i++.
    - VLOAD only: capture `memdataout` into `mem_rdata_q`, and next cycle assert `vrf_we`, `vrf_widx` = i, `vrf_wsel_mem` = 1.
  - Strobes drop for exactly one cycle between elements (one request per element).
  - After the last element's `mem_ready`, go to DRAIN.
- **DRAIN**
  - Complete any pending write-back.
  - Pulse `done`, go to IDLE.
- `issue_valid` while not in IDLE is ignored; the ID stage holds the instruction under `pipe_stall`.
- Reset asserted mid-instruction aborts immediately:
  - Memory strobes fall asynchronously.
  - No further `vrf_we` occurs.
  - `done` does not pulse.

## Timing
- **VALU, vlen = N**
  - Accept at edge 0.
  - Reads in cycles 1..N.
  - `vrf_we` in cycles 2..N+1.
  - DRAIN and `done` in cycle N+1.
  - `pipe_stall` high in cycles 1..N+1; IDLE in cycle N+2.
- **Memory ops**: each element costs (wait cycles + 1) plus one gap cycle. Load write-back occurs one cycle after `mem_ready`.
- `mem_ready` = 1 in the first request cycle is a zero-wait completion and is legal.
- No combinational path from `issue_*` to any output.

## Structure
- Shared package `vemicry_pkg` holds:
  - `issue_op` encodings (VOP_NOP, VOP_ALU, VOP_LD, VOP_ST)
  - the state enumeration
  - VLEN_MAX / width constants
- Sub-module `vec_addr_gen`: address register, stride add, element counter and last-element flag. It has load/step inputs and is reused by the future gather unit.

## Test plan
- VALU, vlen = 4, vs = 1, vd = 2 → `vrf_we` cycles 2-5 with widx 0,1,2,3; `done` in cycle 5; `pipe_stall` high in cycles 1-5.
- VLOAD, base = 0x100, stride = 4, vlen = 3, `mem_ready` after 2 wait cycles → `data_add` 0x100, 0x104, 0x108; loaded values written to vd at idx 0..2.
- VSTORE with `mem_ready` tied high, base = 0xFFFFFFF8, stride = 8, vlen = 2 → `data_add` 0xFFFFFFF8 then 0x00000000; `data_in_mem` equals `vrf_rt_data` for each element.
- NOP and vlen = 0 issues → `pipe_stall` never rises, no `done`. vlen = 12 → exactly 8 elements processed.
- Reset pulled low during a VLOAD wait state → `data_read` falls immediately; after release, state is IDLE and a new VALU issue is accepted and completes normally.
- `issue_valid` toggled during a busy VALU → ignored; only one `done`.
